// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the PC to instruction memory, buffers
// {instr, pc} in a small FIFO for decode, and handles branch/jump redirects.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  im_pc,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [7:0]  out_pc,
  output logic [7:0]  out_pc_plus4,
  output logic        misalign_err,
  output logic [15:0] deliv_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    fetch_pc;
  logic [31:0]   instr_q [DEPTH];
  logic [7:0]    pc_q    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  assign im_pc     = fetch_pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count < CW'(DEPTH)) || pop);

  // Head fields are forced to zero while the FIFO is empty.
  assign out_instr    = out_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_pc       = out_valid ? pc_q[rd_ptr] : 8'h00;
  assign out_pc_plus4 = out_valid ? pc_q[rd_ptr] + 8'd4 : 8'h00;

  // FIFO storage; contents need no reset since out_valid gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_q[wr_ptr] <= im_instr;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[7:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 8'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // A pop that coincides with a redirect is still an accepted instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      deliv_count <= 16'h0000;
    end else if (pop && (deliv_count != 16'hFFFF)) begin
      deliv_count <= deliv_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue of expected PCs is
// filled by each scenario and drained as decode handshakes occur.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  im_pc;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [7:0]  out_pc_plus4;
  logic        misalign_err;
  logic [15:0] deliv_count;

  int          pass_cnt;
  int          chk_cnt;
  int          exp_deliv;
  logic [7:0]  exp_q[$];

  fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .im_pc(im_pc), .im_instr(im_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .misalign_err(misalign_err), .deliv_count(deliv_count)
  );

  function automatic logic [31:0] word(input logic [7:0] a);
    return {a ^ 8'hC3, a, ~a, 8'h5A};
  endfunction

  assign im_instr = word(im_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; any handshake about to happen is checked against the queue.
  task automatic clk_cycle();
    logic [7:0] e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: delivered pc=%h, no delivery expected", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== word(e))
          $display("FAIL sb_deliver: pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, e, word(e));
        else pass_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    clk_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h43; out_ready = 1'b1;
    clk_cycle();
    clk_cycle();
    chk_cnt++; if (im_pc !== 8'h00) $display("FAIL rst_im_pc: got %h exp 00", im_pc); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign: got %b exp 0", misalign_err); else pass_cnt++;
    chk_cnt++; if (deliv_count !== 16'h0) $display("FAIL rst_deliv: got %h exp 0", deliv_count); else pass_cnt++;
    chk_cnt++;
    if (out_instr !== 32'h0 || out_pc !== 8'h0 || out_pc_plus4 !== 8'h0)
      $display("FAIL rst_head_zero: instr=%h pc=%h pc4=%h exp all 0", out_instr, out_pc, out_pc_plus4);
    else pass_cnt++;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    clk_cycle();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b exp 1", out_valid); else pass_cnt++;
    chk_cnt++;
    if (out_pc !== 8'h00 || out_instr !== word(8'h00) || out_pc_plus4 !== 8'h04)
      $display("FAIL first_head: pc=%h instr=%h pc4=%h exp 00 %h 04", out_pc, out_instr, out_pc_plus4, word(8'h00));
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    exp_q.push_back(8'h00); exp_q.push_back(8'h04);
    exp_q.push_back(8'h08); exp_q.push_back(8'h0C);
    out_ready = 1'b1;
    repeat (4) clk_cycle();
    out_ready = 1'b0;
    exp_deliv += 4;
    chk_cnt++; if (deliv_count !== 16'(exp_deliv)) $display("FAIL stream_deliv: got %0d exp %0d", deliv_count, exp_deliv); else pass_cnt++;
    chk_cnt++; if (out_pc !== 8'h10) $display("FAIL stream_next_head: got %h exp 10", out_pc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_deliv = 0;
    repeat (2) clk_cycle();
    chk_cnt++; if (im_pc !== 8'h08) $display("FAIL bp_full_im_pc: got %h exp 08", im_pc); else pass_cnt++;
    repeat (3) clk_cycle();
    chk_cnt++; if (im_pc !== 8'h08) $display("FAIL bp_hold_im_pc: got %h exp 08", im_pc); else pass_cnt++;
    chk_cnt++; if (out_pc !== 8'h00) $display("FAIL bp_hold_head: got %h exp 00", out_pc); else pass_cnt++;
    exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    out_ready = 1'b1;
    repeat (3) clk_cycle();
    out_ready = 1'b0;
    exp_deliv += 3;
    chk_cnt++; if (deliv_count !== 16'(exp_deliv)) $display("FAIL bp_deliv: got %0d exp %0d", deliv_count, exp_deliv); else pass_cnt++;
  endtask

  task automatic test_redirect_full();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL redir_pre_valid: got %b exp 1", out_valid); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    clk_cycle();
    redirect_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_flush: got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (im_pc !== 8'h40) $display("FAIL redir_im_pc: got %h exp 40", im_pc); else pass_cnt++;
    clk_cycle();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== word(8'h40))
      $display("FAIL redir_target: valid=%b pc=%h instr=%h exp 1 40 %h", out_valid, out_pc, out_instr, word(8'h40));
    else pass_cnt++;
    exp_q.push_back(8'h40); exp_q.push_back(8'h44);
    out_ready = 1'b1;
    repeat (2) clk_cycle();
    out_ready = 1'b0;
    exp_deliv += 2;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    clk_cycle();
    redirect_valid = 1'b0;
    clk_cycle();
    chk_cnt++;
    if (out_pc !== 8'hFC || out_pc_plus4 !== 8'h00)
      $display("FAIL wrap_head: pc=%h pc4=%h exp FC 00", out_pc, out_pc_plus4);
    else pass_cnt++;
    exp_q.push_back(8'hFC); exp_q.push_back(8'h00);
    out_ready = 1'b1;
    repeat (2) clk_cycle();
    out_ready = 1'b0;
    exp_deliv += 2;
    chk_cnt++; if (misalign_err !== 1'b0) $display("FAIL wrap_no_misalign: got %b exp 0", misalign_err); else pass_cnt++;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 8'h43;
    clk_cycle();
    redirect_valid = 1'b0;
    chk_cnt++; if (im_pc !== 8'h40) $display("FAIL mis_im_pc: got %h exp 40", im_pc); else pass_cnt++;
    chk_cnt++; if (misalign_err !== 1'b1) $display("FAIL mis_set: got %b exp 1", misalign_err); else pass_cnt++;
    clk_cycle();
    chk_cnt++; if (out_pc !== 8'h40) $display("FAIL mis_head: got %h exp 40", out_pc); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    clk_cycle();
    redirect_valid = 1'b0;
    chk_cnt++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky: got %b exp 1", misalign_err); else pass_cnt++;
  endtask

  task automatic test_redirect_pop();
    clk_cycle();
    exp_q.push_back(8'h80);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
    clk_cycle();
    out_ready = 1'b0; redirect_valid = 1'b0;
    exp_deliv += 1;
    chk_cnt++; if (deliv_count !== 16'(exp_deliv)) $display("FAIL rp_deliv: got %0d exp %0d", deliv_count, exp_deliv); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rp_empty: got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (im_pc !== 8'h20) $display("FAIL rp_im_pc: got %h exp 20", im_pc); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    chk_cnt++; if (misalign_err !== 1'b0) $display("FAIL sat_misalign_clr: got %b exp 0", misalign_err); else pass_cnt++;
    out_ready = 1'b1;
    repeat (65535) begin @(posedge clk); #1; end
    chk_cnt++; if (deliv_count !== 16'hFFFE) $display("FAIL sat_pre: got %h exp FFFE", deliv_count); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (deliv_count !== 16'hFFFF) $display("FAIL sat_reach: got %h exp FFFF", deliv_count); else pass_cnt++;
    repeat (4) begin @(posedge clk); #1; end
    chk_cnt++; if (deliv_count !== 16'hFFFF) $display("FAIL sat_hold: got %h exp FFFF", deliv_count); else pass_cnt++;
    chk_cnt++;
    if (out_pc !== 8'((65540 - 1) * 4))
      $display("FAIL sat_seq_pc: got %h exp %h", out_pc, 8'((65540 - 1) * 4));
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; chk_cnt = 0; exp_deliv = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_misalign();
    test_redirect_pop();
    test_saturation();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d entries never delivered, exp 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of the instruction memory. It owns the 8-bit byte-addressed PC and drives it to the memory. It captures the combinational 32-bit instruction that comes back in the same cycle into a small FIFO, then hands {instruction, PC} to decode over a valid/ready handshake. Decode/execute redirect it for branches and jumps; it flushes stale entries and counts delivered instructions.

Parameters:
DEPTH, 2, fetch FIFO entries; power of two, at least 2.
RESET_PC, 8'h00, PC loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
im_pc  output  8  byte address to instruction memory; combinationally equals fetch_pc.
im_instr  input  32  instruction word returned by instruction memory for im_pc, same cycle.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  8  target byte address for redirect.
out_valid  output  1  FIFO head holds a valid instruction.
out_ready  input  1  decode accepts head this cycle.
out_instr  output  32  head instruction word.
out_pc  output  8  head instruction byte address.
out_pc_plus4  output  8  out_pc + 4, modulo 256.
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] non-zero.
deliv_count  output  16  number of instructions accepted by decode; saturates at 16'hFFFF.

Behaviour:
- Reset (rst high at the clock edge):
  - fetch_pc <= RESET_PC; FIFO count <= 0; read/write pointers <= 0.
  - Storage does not need clearing, but out_instr, out_pc and out_pc_plus4 must read 0 while out_valid = 0.
  - misalign_err <= 0; deliv_count <= 0.
  - rst overrides all other inputs in that cycle, including a redirect or handshake in flight.
- pop = out_valid && out_ready. out_valid = (count != 0). Head fields come straight from FIFO storage, with no combinational path from im_instr.
- push allowed = !redirect_valid && (count < DEPTH || pop). Pushing into a full FIFO is legal only when a pop happens in the same cycle.
- On push: write {im_instr, fetch_pc} at the write pointer, advance the write pointer, then fetch_pc <= fetch_pc + 4 (8-bit wrap: 8'hFC -> 8'h00).
- When not pushing and not redirecting: fetch_pc holds, so im_pc is stable under backpressure.
- Redirect (redirect_valid = 1), highest priority after rst:
  - FIFO cleared: count <= 0, pointers <= 0.
  - fetch_pc <= {redirect_pc[7:2], 2'b00}.
  - No push in that cycle.
  - If redirect_pc[1:0] != 0, misalign_err <= 1; it stays set until rst.
  - A pop handshake in the same cycle still counts as accepted (deliv_count increments). The entry is flushed regardless.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Pointer arithmetic is modulo DEPTH.
- deliv_count increments by 1 on each pop and holds at 16'hFFFF.
- Latency:
  - The first cycle after rst deassertion pushes RESET_PC; out_valid = 1 the following cycle.
  - Redirect to first valid target: the redirect cycle, then the push cycle, then out_valid in the next cycle (2 cycles).
- Steady state with out_ready = 1: one instruction per cycle, PCs strictly sequential.
- Ordering: no loss, duplication or reordering of entries outside a redirect.

Test Plan:
- Reset: hold rst 2 cycles with redirect_valid = 1 -> im_pc = 8'h00, out_valid = 0, misalign_err = 0, deliv_count = 0. One cycle after release out_valid = 1, out_pc = 8'h00, out_instr = word at address 0, out_pc_plus4 = 8'h04.
- Streaming: out_ready = 1 constantly -> out_pc = 00, 04, 08, 0C on consecutive cycles; deliv_count = 4 after 4 handshakes.
- Backpressure: out_ready = 0 from reset release (DEPTH = 2) -> FIFO fills after 2 cycles, im_pc holds 8'h08, out_pc stays 8'h00. Raise out_ready -> 00, 04, 08 delivered in order with no gaps.
- Redirect while FIFO full to 8'h40 -> next cycle out_valid = 0, im_pc = 8'h40; following cycle out_pc = 8'h40, out_instr = word at 0x40; stale 00/04 entries are never delivered.
- Wrap/misalign:
  - Redirect to 8'hFC -> out_pc sequence FC, 00, and out_pc_plus4 = 8'h00 at FC.
  - Redirect to 8'h43 -> fetch from 8'h40 and misalign_err = 1, persisting until rst.
- Simultaneous redirect and pop: with out_valid = 1, out_ready = 1 and redirect_valid = 1 -> deliv_count increments by 1 and the FIFO is empty the next cycle.
- Saturation: preload 65535 handshakes (or force the counter) -> deliv_count stays at 16'hFFFF.
